pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage core. It arbitrates stall, redirect and trap requests from ID, EX, the fetch bus and the interrupt source. It drives the hold level and redirect (jump flag/address) consumed by pc_reg and the IF/ID/EX pipeline registers. It also sequences interrupt entry and fetch-bus timeout through a small state machine.

Parameters:
TRAP_VEC, 32'h0000_0100, trap/interrupt entry address.
BUS_TIMEOUT, 16, consecutive fetch-stall cycles before a bus-error trap (legal range 2..255).
HOLD_W, 3, width of the hold flag bus.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, active-low, synchronous.
id_stall_i  in  1  load-use hazard from ID.
ex_busy_i  in  1  EX multi-cycle op (div) in progress.
ex_jump_i  in  1  EX branch/jump taken.
ex_jump_addr_i  in  32  EX redirect target.
ex_pc_i  in  32  PC of instruction in EX.
bus_stall_i  in  1  instruction fetch not yet granted/returned.
irq_i  in  1  level interrupt request.
irq_en_i  in  1  global interrupt enable (CSR).
hold_flag_o  out  HOLD_W  0=none, 1=hold PC, 2=hold PC+IF, 3=hold PC+IF+ID.
jump_flag_o  out  1  redirect PC this cycle.
jump_addr_o  out  32  redirect target.
flush_o  out  1  kill IF/ID/EX contents.
trap_o  out  1  one-cycle trap-entry pulse (to CSR).
trap_cause_o  out  2  0=none, 1=interrupt, 2=bus timeout.
epc_o  out  32  PC saved for trap return; valid when trap_o=1.

Behaviour:
- Reset (rst_ni=0 on a clk_i edge): state=RUN, pending-redirect valid=0, timeout counter=0, epc register=0. All outputs are 0 during and after reset until new requests arrive.
- States: RUN, DRAIN, TRAP.
- RUN, output priority (highest first):
  - pending redirect valid and bus_stall_i=0 -> jump_flag_o=1, jump_addr_o=pending target, flush_o=1, clear pending.
  - ex_jump_i=1 and bus_stall_i=0 -> jump_flag_o=1, jump_addr_o=ex_jump_addr_i, flush_o=1.
  - ex_jump_i=1 and bus_stall_i=1 -> latch ex_jump_addr_i into pending; hold=1; flush_o=1 that cycle.
  - ex_busy_i=1 -> hold=3.
  - id_stall_i=1 -> hold=2.
  - bus_stall_i=1 -> hold=1.
  - otherwise hold=0.
  - hold_flag_o and jump_flag_o are combinational in RUN, with zero-cycle latency.
- A new ex_jump_i arriving while pending is already valid overwrites pending (the younger EX redirect wins).
- RUN -> DRAIN when irq_i & irq_en_i and no redirect is issued this cycle. A redirect this cycle defers the interrupt one cycle.
- DRAIN:
  - hold=3, no jump.
  - Stays while ex_busy_i=1.
  - When ex_busy_i=0: latch epc=ex_pc_i, cause=1, then go to TRAP.
  - If irq_i drops while in DRAIN, the interrupt is still taken (committed on entry).
- Bus timeout:
  - Counter increments each cycle bus_stall_i=1 in RUN and clears when bus_stall_i=0. It saturates, with no wrap.
  - When the count reaches BUS_TIMEOUT-1 with bus_stall_i still 1: latch epc=ex_pc_i, cause=2, go to TRAP. This has priority over irq entry.
- TRAP (exactly one cycle):
  - jump_flag_o=1, jump_addr_o=TRAP_VEC, flush_o=1, trap_o=1, trap_cause_o=latched cause, epc_o=latched epc, hold=0.
  - Clears pending redirect and timeout counter, then returns to RUN.
  - Inputs are ignored in TRAP.
- Outside TRAP: trap_o=0 and trap_cause_o=0. epc_o holds the last latched value.
- Reset asserted in any state returns to RUN at the next edge, dropping any pending redirect or trap.

Test Plan:
- Reset, then all inputs idle -> hold=0, jump=0, flush=0. Deassert rst_ni with bus_stall_i=1 for 3 cycles -> hold=1 for those 3 cycles.
- ex_jump_i=1, addr=32'h0000_2040, bus_stall_i=0 -> same cycle jump_flag_o=1, jump_addr_o=32'h2040, flush_o=1.
- ex_jump_i pulse with addr=32'h3000 while bus_stall_i=1 for 4 more cycles -> hold=1 during the stall; jump to 32'h3000 in the first cycle bus_stall_i=0; single-cycle jump only.
- id_stall_i=1 and ex_busy_i=1 together -> hold=3. Drop ex_busy_i -> hold=2.
- irq_i=1, irq_en_i=1, ex_busy_i=1 for 5 cycles, ex_pc_i=32'h0000_0A10 -> DRAIN with hold=3 for 5 cycles. Next cycle is TRAP: jump to 32'h0100, trap_o=1, cause=1, epc_o=32'h0A10. Then back to RUN.
- bus_stall_i held high for 16 cycles (BUS_TIMEOUT=16) -> TRAP in cycle 16 with cause=2. Assert rst_ni=0 during DRAIN -> RUN next cycle, no trap_o.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/redirect/trap arbitration and interrupt/bus-timeout sequencing for the 5-stage core
module pipe_ctrl #(
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int          BUS_TIMEOUT = 16,
    parameter int          HOLD_W      = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_stall_i,
    input  logic              ex_busy_i,
    input  logic              ex_jump_i,
    input  logic [31:0]       ex_jump_addr_i,
    input  logic [31:0]       ex_pc_i,
    input  logic              bus_stall_i,
    input  logic              irq_i,
    input  logic              irq_en_i,
    output logic [HOLD_W-1:0] hold_flag_o,
    output logic              jump_flag_o,
    output logic [31:0]       jump_addr_o,
    output logic              flush_o,
    output logic              trap_o,
    output logic [1:0]        trap_cause_o,
    output logic [31:0]       epc_o
);
    typedef enum logic [1:0] {RUN, DRAIN, TRAP} state_t;
    state_t      state;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic [31:0] epc;
    logic [7:0]  cnt;
    logic [1:0]  cause;
    logic        run, drain, trap, redir_p, redir_e, latch, tmo, irq_go;
    always_comb begin
        run         = rst_ni && state == RUN;
        drain       = rst_ni && state == DRAIN;
        trap        = rst_ni && state == TRAP;
        redir_p     = run && pend_v && !bus_stall_i;
        redir_e     = run && !pend_v && ex_jump_i && !bus_stall_i;
        latch       = run && ex_jump_i && bus_stall_i;
        tmo         = run && bus_stall_i && cnt == 8'(BUS_TIMEOUT - 2);
        irq_go      = run && irq_i && irq_en_i && !redir_p && !redir_e && !tmo;
        jump_flag_o = redir_p || redir_e || trap;
        jump_addr_o = trap ? TRAP_VEC : redir_p ? pend_addr : redir_e ? ex_jump_addr_i : '0;
        flush_o     = jump_flag_o || latch;
        hold_flag_o = drain ? HOLD_W'(3) :
                      (!run || redir_p || redir_e) ? HOLD_W'(0) :
                      latch ? HOLD_W'(1) :
                      ex_busy_i ? HOLD_W'(3) :
                      id_stall_i ? HOLD_W'(2) :
                      bus_stall_i ? HOLD_W'(1) : HOLD_W'(0);
        trap_o       = trap;
        trap_cause_o = trap ? cause : 2'd0;
        epc_o        = rst_ni ? epc : '0;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= RUN;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            cnt       <= '0;
            epc       <= '0;
            cause     <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (redir_p) pend_v <= 1'b0;
                    if (latch) begin
                        pend_v    <= 1'b1;
                        pend_addr <= ex_jump_addr_i;
                    end
                    cnt <= !bus_stall_i ? 8'd0 : cnt == 8'hff ? cnt : cnt + 8'd1;
                    if (tmo) begin
                        epc   <= ex_pc_i;
                        cause <= 2'd2;
                        state <= TRAP;
                    end else if (irq_go) state <= DRAIN;
                end
                DRAIN: if (!ex_busy_i) begin
                    epc   <= ex_pc_i;
                    cause <= 2'd1;
                    state <= TRAP;
                end
                default: begin
                    pend_v <= 1'b0;
                    cnt    <= '0;
                    state  <= RUN;
                end
            endcase
        end
    end
endmodule
